// File: rtl/out_pack_ctrl.sv
// out_pack_ctrl: sequences the output packer. Arbitrates adder sets for frame
// space round-robin, hands out slot offsets, tracks the fill level and drains
// a full (or flushed) frame downstream through a valid/ready handshake.
module out_pack_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_OF_MUL     = 14,
  parameter int DATA_OF_SET    = 128,
  parameter int OUT_NUM_OF_SET = 3,
  parameter int PTR_W          = $clog2(DATA_OF_SET + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OUT_NUM_OF_SET-1:0]       adder_req,
  output logic [OUT_NUM_OF_SET-1:0]       adder_valid,
  output logic [OUT_NUM_OF_SET*PTR_W-1:0] slot_base,
  input  logic                            flush,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [PTR_W-1:0]                dout_words
);

  localparam int RR_W = (OUT_NUM_OF_SET > 1) ? $clog2(OUT_NUM_OF_SET) : 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // A frame must hold at least one set's worth of results.
  if (DATA_OF_SET < NUM_OF_MUL || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("out_pack_ctrl: DATA_OF_SET must be >= NUM_OF_MUL");
  end

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              flush_pend_q, flush_pend_d;

  int                free_slots;
  int                grant_cnt;
  int                scan_idx;
  logic [RR_W-1:0]   last_idx;
  logic [PTR_W-1:0]  wr_upd;

  // Grant selection: scan from rr_ptr, grant the first requesters that fit.
  always_comb begin
    adder_valid = '0;
    slot_base   = '0;
    grant_cnt   = 0;
    scan_idx    = 0;
    last_idx    = rr_ptr_q;
    free_slots  = (DATA_OF_SET - int'(wr_ptr_q)) / NUM_OF_MUL;
    // NOTE: grants are gated by rst so the combinational outputs read zero
    // while reset is held, matching the registered outputs.
    if (rst && state_q == ST_FILL) begin
      for (int j = 0; j < OUT_NUM_OF_SET; j++) begin
        scan_idx = (int'(rr_ptr_q) + j) % OUT_NUM_OF_SET;
        if (adder_req[scan_idx] && grant_cnt < free_slots) begin
          adder_valid[scan_idx] = 1'b1;
          slot_base[scan_idx*PTR_W +: PTR_W] =
            wr_ptr_q + PTR_W'(grant_cnt * NUM_OF_MUL);
          grant_cnt = grant_cnt + 1;
          last_idx  = RR_W'(scan_idx);
        end
      end
    end
  end

  // Next-state: fill pointer, round-robin start and FILL/DRAIN sequencing.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rr_ptr_d     = rr_ptr_q;
    flush_pend_d = flush_pend_q;
    wr_upd       = wr_ptr_q + PTR_W'(grant_cnt * NUM_OF_MUL);
    case (state_q)
      ST_FILL: begin
        wr_ptr_d = wr_upd;
        if (grant_cnt > 0) begin
          rr_ptr_d = RR_W'((int'(last_idx) + 1) % OUT_NUM_OF_SET);
        end
        // A flush either closes the frame now or is dropped on an empty one.
        flush_pend_d = 1'b0;
        if ((DATA_OF_SET - int'(wr_upd)) < NUM_OF_MUL ||
            ((flush || flush_pend_q) && wr_upd != '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Flushes are ignored here: the frame is already closing.
        if (dout_ready) begin
          state_d  = ST_FILL;
          wr_ptr_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State registers; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      rr_ptr_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the next-state logic.
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign dout_valid = (state_q == ST_DRAIN);
  assign dout_words = dout_valid ? wr_ptr_q : '0;

endmodule

// File: tb/tb_out_pack_ctrl.sv
// tb_out_pack_ctrl: directed test-plan cases plus randomized traffic, checked
// by a scoreboard fed from a behavioural frame-packing model.
module tb_out_pack_ctrl;

  localparam int N  = 3;
  localparam int NM = 14;
  localparam int DS = 128;
  localparam int PW = $clog2(DS + 1);

  logic          clk;
  logic          rst;
  logic [N-1:0]  adder_req;
  logic [N-1:0]  adder_valid;
  logic [N*PW-1:0] slot_base;
  logic          flush;
  logic          dout_valid;
  logic          dout_ready;
  logic [PW-1:0] dout_words;

  out_pack_ctrl #(
    .DATA_WIDTH(32), .NUM_OF_MUL(NM), .DATA_OF_SET(DS), .OUT_NUM_OF_SET(N)
  ) dut (
    .clk(clk), .rst(rst), .adder_req(adder_req), .adder_valid(adder_valid),
    .slot_base(slot_base), .flush(flush), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_words(dout_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  av;
    int            base [N];
    logic          dv;
    int            words;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  // Model state: words in the frame, scan start, and whether the frame drains.
  int   m_wr    = 0;
  int   m_rr    = 0;
  bit   m_drain = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int base_of(input int i);
    logic [N*PW-1:0] v;
    v = slot_base;
    return int'(v[i*PW +: PW]);
  endfunction

  // Requesting sets in round-robin order, trimmed to what fits in the frame.
  function automatic void granted(input logic [N-1:0] req, output int list[$]);
    int order[$];
    list = {};
    if (m_drain) return;
    for (int j = 0; j < N; j++) if (req[(m_rr + j) % N]) order.push_back((m_rr + j) % N);
    for (int j = 0; j < order.size() && j < (DS - m_wr) / NM; j++) list.push_back(order[j]);
  endfunction

  task automatic apply(input logic [N-1:0] req, input logic fl, input logic rdy);
    exp_t e;
    int   list[$];
    adder_req  = req;
    flush      = fl;
    dout_ready = rdy;
    granted(req, list);
    e.av = '0;
    for (int i = 0; i < N; i++) e.base[i] = 0;
    foreach (list[j]) begin
      e.av[list[j]]   = 1'b1;
      e.base[list[j]] = m_wr + j * NM;
    end
    e.dv    = m_drain;
    e.words = m_drain ? m_wr : 0;
    exp_q.push_back(e);
  endtask

  // Advance one clock and move the model with the inputs sampled at that edge.
  task automatic tick();
    int list[$];
    granted(adder_req, list);
    @(posedge clk);
    if (!m_drain) begin
      m_wr += list.size() * NM;
      if (list.size() > 0) m_rr = (list[list.size()-1] + 1) % N;
      if ((DS - m_wr) < NM || (flush && m_wr > 0)) m_drain = 1'b1;
    end else if (dout_ready) begin
      m_drain = 1'b0;
      m_wr    = 0;
    end
    #1;
  endtask

  // Monitor: compares what the DUT presents against the queued expectation.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(adder_valid == e.av, "adder_valid", int'(adder_valid), int'(e.av));
      for (int i = 0; i < N; i++)
        if (e.av[i]) check(base_of(i) == e.base[i], "slot_base", base_of(i), e.base[i]);
      check(dout_valid == e.dv, "dout_valid", int'(dout_valid), int'(e.dv));
      check(int'(dout_words) == e.words, "dout_words", int'(dout_words), e.words);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b0; adder_req = 3'b111; flush = 1'b0; dout_ready = 1'b0;
    #12;
    check(adder_valid == 0, "rst_adder_valid", int'(adder_valid), 0);
    check(slot_base == 0, "rst_slot_base", int'(slot_base != 0), 0);
    check(dout_valid == 0, "rst_dout_valid", int'(dout_valid), 0);
    check(dout_words == 0, "rst_dout_words", int'(dout_words), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Multi-grant from an empty frame.
    apply(3'b101, 0, 0); #2;
    check(adder_valid == 3'b101, "multi_grant", int'(adder_valid), 5);
    check(base_of(2) == 14, "multi_base2", base_of(2), 14);
    tick();
    apply(3'b001, 0, 0); #2;
    check(base_of(0) == 28, "wr_ptr_after_multi", base_of(0), 28);
    tick();
    // Flush a 42-word frame.
    apply(3'b000, 1, 0); tick();
    apply(3'b000, 0, 0); #2;
    check(dout_words == 42, "flush_words", int'(dout_words), 42);
    tick();
    apply(3'b000, 0, 1); tick();
    // Fill to 112 with rr_ptr=1, then hit the capacity limit.
    apply(3'b111, 0, 0); tick();
    apply(3'b111, 0, 0); tick();
    apply(3'b001, 0, 0); tick();
    apply(3'b001, 0, 0); tick();
    apply(3'b111, 0, 0); #2;
    check(adder_valid == 3'b010, "cap_grant", int'(adder_valid), 2);
    check(base_of(1) == 112, "cap_base1", base_of(1), 112);
    tick();
    // Backpressure for five cycles.
    for (int c = 0; c < 5; c++) begin
      apply(3'b111, 0, 0); #2;
      check(dout_valid && adder_valid == 0 && dout_words == 126, "backpressure",
            int'(dout_words), 126);
      tick();
    end
    apply(3'b111, 0, 1); tick();
    apply(3'b111, 0, 0); #2;
    check(adder_valid == 3'b111 && base_of(2) == 0 && base_of(0) == 14,
          "post_drain_rr", base_of(0), 14);
    tick();
    apply(3'b000, 1, 0); tick();
    apply(3'b000, 0, 1); tick();
    // Flush on an empty frame is dropped.
    apply(3'b000, 1, 0); tick();
    apply(3'b000, 0, 0); #2;
    check(dout_valid == 0, "flush_empty", int'(dout_valid), 0);
    tick();
    // Flush together with a grant on an empty frame.
    apply(3'b001, 1, 0); tick();
    apply(3'b000, 0, 1); #2;
    check(dout_words == 14, "flush_with_grant", int'(dout_words), 14);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      apply(N'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      tick();
    end

    // Reset in the middle of a drain.
    for (int c = 0; c < 20 && !dout_valid; c++) begin
      apply(3'b111, 1, 0); tick();
    end
    check(dout_valid == 1, "reach_drain", int'(dout_valid), 1);
    mon_en = 1'b0;
    @(negedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    #1;
    check(dout_valid == 0 && dout_words == 0, "async_rst_drain", int'(dout_words), 0);
    m_wr = 0; m_rr = 0; m_drain = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    apply(3'b001, 0, 0); #2;
    check(adder_valid == 3'b001 && base_of(0) == 0, "after_rst_fill", base_of(0), 0);
    tick();
    apply(3'b000, 0, 0); tick();
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/out_pack_ctrl.md
# out_pack_ctrl

Controller that sequences the output-packing datapath, which collects adder-set results into one DATA_OF_SET-word output frame. It arbitrates OUT_NUM_OF_SET adder sets competing for frame space, issues the per-set write-valid mask and slot offsets, and tracks frame fill level. When the frame is full or flushed, it drains the frame downstream through a valid/ready handshake. It sits between the adder array and the output buffer.

## Interface
- DATA_WIDTH, 32: word width; informational only, no datapath in this block.
- NUM_OF_MUL, 14: words produced per adder set per grant.
- DATA_OF_SET, 128: frame capacity in words.
- OUT_NUM_OF_SET, 3: number of adder sets (requesters).
- PTR_W, $clog2(DATA_OF_SET+1): width of offsets and counts.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- adder_req  in  OUT_NUM_OF_SET  set i holds NUM_OF_MUL results; held until granted.
- adder_valid  out  OUT_NUM_OF_SET  grant mask, driven to the packer's write-valid input.
- slot_base  out  OUT_NUM_OF_SET×PTR_W  word offset where granted set i writes; don't-care if not granted.
- flush  in  1  single-cycle pulse that closes a partial frame.
- dout_valid  out  1  frame complete and held for downstream.
- dout_ready  in  1  downstream accepts the frame.
- dout_words  out  PTR_W  number of valid words in the frame; unused words are zero, written by the packer.

## Operation
- State register has two states: FILL and DRAIN. Reset state is FILL.
- Registers:
  - wr_ptr (PTR_W): words used in the current frame.
  - rr_ptr ($clog2(OUT_NUM_OF_SET)): round-robin start index.
  - flush_pend (1 bit).
- free_slots = (DATA_OF_SET − wr_ptr) / NUM_OF_MUL, using integer division.
- Grant selection in FILL is combinational from adder_req and registered state:
  - Scan indices rr_ptr, rr_ptr+1, … modulo OUT_NUM_OF_SET.
  - Grant the first k requesting sets, where k = min(popcount(adder_req), free_slots).
- Placement: granted sets take consecutive slots in scan order. The j-th granted set gets slot_base = wr_ptr + j·NUM_OF_MUL.
- FILL update on each clock edge:
  - wr_ptr += k·NUM_OF_MUL.
  - If k>0, rr_ptr = (index of last granted set + 1) mod OUT_NUM_OF_SET. Otherwise rr_ptr is unchanged.
- FILL→DRAIN occurs when either condition holds:
  - the updated wr_ptr leaves fewer than NUM_OF_MUL words free (default: 9 slots, 126 words);
  - flush, or flush_pend, is seen with updated wr_ptr > 0.
- Flush with wr_ptr = 0 and no grant that cycle is ignored, and flush_pend is cleared.
- Flush coinciding with grants: the grants are taken, then the frame drains.
- DRAIN behaviour:
  - adder_valid = 0.
  - dout_valid = 1 and dout_words = wr_ptr; both are stable until dout_ready.
  - Requests stay pending.
  - A flush arriving in DRAIN is ignored, because the frame is already closing.
- DRAIN→FILL occurs on the edge where dout_ready = 1. At that edge wr_ptr ← 0, and rr_ptr and flush_pend are kept.
- Reset asserted at any time, including mid-DRAIN: the current frame is discarded and all registers clear immediately.
- Reset values:
  - adder_valid = 0, slot_base = 0, dout_valid = 0, dout_words = 0.
  - wr_ptr = 0, rr_ptr = 0, flush_pend = 0, state FILL.
- Elaboration check: a configuration with DATA_OF_SET < NUM_OF_MUL is rejected.

## Timing
- Grant latency is 0 cycles: adder_valid and slot_base respond combinationally to adder_req in the same cycle. The packer writes on the following edge.
- wr_ptr reflects a grant one cycle after it.
- dout_valid rises one cycle after the filling grant or the flush.
- A frame is released on the dout_valid && dout_ready edge. The earliest next grant is the cycle after that edge.
- Minimum frame turnaround is 1 DRAIN cycle with dout_ready held high.
- With back-to-back frames, the adders see a 1-cycle grant bubble per drain.

## Test plan
- Reset: hold rst=0 with adder_req=3'b111 → all outputs 0. After release, state is FILL and grants begin the same cycle.
- Multi-grant: wr_ptr=0, rr_ptr=0, adder_req=3'b101 → adder_valid=3'b101, slot_base[0]=0, slot_base[2]=14. Next cycle: wr_ptr=28, rr_ptr=0.
- Capacity limit and round-robin: wr_ptr=112, rr_ptr=1, adder_req=3'b111 → adder_valid=3'b010, slot_base[1]=112. Next cycle: wr_ptr=126, rr_ptr=2, dout_valid=1, dout_words=126.
- Backpressure: in DRAIN, hold dout_ready=0 for 5 cycles with adder_req=3'b111 → dout_valid stays 1 and adder_valid stays 0. Pulse dout_ready=1 → the next cycle is FILL, wr_ptr=0, and grants are issued per rr_ptr.
- Flush:
  - flush at wr_ptr=42 with no requests → dout_words=42 the next cycle.
  - flush at wr_ptr=0 → no DRAIN.
  - flush together with adder_req=3'b001 at wr_ptr=0 → grant taken, DRAIN with dout_words=14.
- Reset mid-DRAIN: rst=0 while dout_valid=1 → dout_valid and dout_words drop to 0 asynchronously, before the next clock edge. After release, state is FILL and wr_ptr=0.
